// File: rtl/ttl_counter_updown.sv
// ttl_counter_updown
// ------------------
// Synchronous, cascadable up/down counter in the spirit of a 74191/74163. It
// supports any width and modulus, and adds two extra outputs:
//   - a registered wrap pulse;
//   - a saturating count of wraps since reset.
//
// Ports
//   clock     in   single clock, all state changes on the rising edge
//   reset     in   synchronous active-high reset (highest priority)
//   load      in   synchronous parallel load of d (beats counting)
//   d         in   [WIDTH]  parallel load data; values >= MODULUS clamp
//   enp       in   count enable P (does not gate rco)
//   ent       in   count enable T (also gates rco, cascade input)
//   up        in   1 = count up, 0 = count down
//   q         out  [WIDTH]  current count, 0..MODULUS-1
//   rco       out  combinational ripple carry, feeds the next stage's ent
//   wrap      out  one-cycle registered pulse after a wrapping count step
//   load_err  out  one-cycle registered pulse after an out-of-range load
//   wrap_cnt  out  [8]  wraps since reset, saturating at 255
//
// Parameters
//   WIDTH 1..16, MODULUS 2..2**WIDTH, RESET_VALUE < MODULUS.
module ttl_counter_updown #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 16,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             wrap,
  output logic             load_err,
  output logic [7:0]       wrap_cnt
);

  localparam int               LAST_I = MODULUS - 1;
  localparam logic [WIDTH:0]   MOD_W  = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0]   ONE_W  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LAST_Q = LAST_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_Q  = RESET_VALUE[WIDTH-1:0];

  // Compare and step in WIDTH+1 bits, so MODULUS = 2**WIDTH is representable.
  // With MODULUS = 2**WIDTH, q+1 at the last value reaches MODULUS instead of
  // aliasing to 0.
  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] q_inc;
  logic [WIDTH:0] q_dec;
  logic           at_last;
  logic           at_zero;
  logic           d_ok;

  assign q_ext   = {1'b0, q};
  assign q_inc   = q_ext + ONE_W;
  assign q_dec   = q_ext - ONE_W;
  assign at_last = (q_inc == MOD_W);
  assign at_zero = q_dec[WIDTH];            // borrow out of 0
  assign d_ok    = ({1'b0, d} < MOD_W);

  // Terminal-count carry. It looks only at ent, up and q, so it responds in
  // the same cycle to a direction change.
  assign rco = ent & (up ? at_last : at_zero);

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             err_next;

  // Priority: load over count over hold. Reset is applied in the register.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    if (load) begin
      if (d_ok) begin
        q_next = d;
      end else begin
        q_next   = LAST_Q;
        err_next = 1'b1;
      end
    end else if (enp && ent) begin
      if (up) begin
        if (at_last) begin
          q_next    = '0;
          wrap_next = 1'b1;
        end else begin
          q_next = q_inc[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
          q_next    = LAST_Q;
          wrap_next = 1'b1;
        end else begin
          q_next = q_dec[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q        <= RST_Q;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      wrap_cnt <= 8'd0;
    end else begin
      q        <= q_next;
      wrap     <= wrap_next;
      load_err <= err_next;
      if (wrap_next && (wrap_cnt != 8'hFF)) begin
        wrap_cnt <= wrap_cnt + 8'd1;
      end
    end
  end

endmodule
